odd_even_sorter: RTL

Sequential, parametrised sorter for unsigned words: collects a frame of DEPTH words over a valid/ready input stream, sorts it in place with an odd-even transposition network (one compare-exchange phase per clock), then streams the sorted frame out over a valid/ready output. It is the clocked, streaming-capable generation of the team's combinational array sorter. It sits between a producer and a consumer in a datapath. Direction is selectable per frame, and throughput is one word per cycle on both ports.

---
 rtl/sort_pkg.sv | 14 +
 rtl/odd_even_sorter_cmp_swap.sv | 27 ++
 rtl/odd_even_sorter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types for the odd-even transposition sorter.
// State encoding and sort-direction constants.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  localparam logic SORT_ASC  = 1'b0;
  localparam logic SORT_DESC = 1'b1;

endpackage

// File: rtl/odd_even_sorter_cmp_swap.sv
// Single compare-exchange cell of the transposition network.
// Equal words never swap, keeping the sort stable.
module cmp_swap
  import sort_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dir,
  input  logic             en,
  output logic [WIDTH-1:0] lo_pos,
  output logic [WIDTH-1:0] hi_pos,
  output logic             swapped
);

  logic out_of_order;

  // Swap the pair when enabled and out of order for the direction
  always_comb begin
    out_of_order = (dir == SORT_DESC) ? (a < b) : (a > b);
    swapped      = en && out_of_order;
    lo_pos       = swapped ? b : a;
    hi_pos       = swapped ? a : b;
  end

endmodule

// File: rtl/odd_even_sorter.sv
// Streaming odd-even transposition sorter: load, sort, drain.
// Option SORT_EARLY_EXIT_EN: stop sorting after two idle phases.
module odd_even_sorter
  import sort_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_desc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];

  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] phase;
  logic          dir;

  logic [DEPTH-2:0] cell_en;
  logic [DEPTH-2:0] cell_sw;
  logic [WIDTH-1:0] cell_lo [DEPTH-1];
  logic [WIDTH-1:0] cell_hi [DEPTH-1];

  logic in_fire;
  logic out_fire;
  logic sort_done;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  for (genvar k = 0; k < DEPTH - 1; k++) begin : g_cell
    assign cell_en[k] = (state == SORT) && (phase[0] == 1'(k % 2));

    cmp_swap #(
      .WIDTH(WIDTH)
    ) u_cmp (
      .a      (mem[k]),
      .b      (mem[k+1]),
      .dir    (dir),
      .en     (cell_en[k]),
      .lo_pos (cell_lo[k]),
      .hi_pos (cell_hi[k]),
      .swapped(cell_sw[k])
    );
  end

`ifdef SORT_EARLY_EXIT_EN
  logic prev_sw;

  // Remember whether the previous phase moved anything
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sw <= 1'b0;
    end else if (state == SORT) begin
      prev_sw <= |cell_sw;
    end
  end

  assign sort_done = (phase == LAST) ||
                     ((phase != '0) && !prev_sw && !(|cell_sw));
`else
  logic unused_sw;
  assign unused_sw = ^cell_sw;
  assign sort_done = (phase == LAST);
`endif

  // Merge active cell results; enabled cells never overlap
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_nxt[i] = mem[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (cell_en[i]) begin
        mem_nxt[i]   = cell_lo[i];
        mem_nxt[i+1] = cell_hi[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs from registered state only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = !rst;
        if (in_fire && (wr_cnt == LAST)) begin
          state_nxt = SORT;
        end
      end
      SORT: begin
        busy = 1'b1;
        if (sort_done) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = mem[rd_cnt];
        out_last  = (rd_cnt == LAST);
        if (out_ready && out_last) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Frame buffer, counters, phase and direction
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      phase  <= '0;
      dir    <= SORT_ASC;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        LOAD: begin
          if (in_fire) begin
            mem[wr_cnt] <= in_data;
            if (wr_cnt == '0) begin
              dir <= in_desc;
            end
            if (wr_cnt == LAST) begin
              wr_cnt <= '0;
              phase  <= '0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        SORT: begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= mem_nxt[i];
          end
          phase <= sort_done ? '0 : phase + 1'b1;
        end
        DRAIN: begin
          if (out_fire) begin
            rd_cnt <= out_last ? '0 : rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
